display_7seg_barrido: RTL

- Time-multiplexed 4-digit 7-segment display driver. Sits directly downstream of the frequency/current digit selector and consumes its four 4-bit digit outputs.
- Scans one digit per refresh tick and decodes the nibble to segments. Drives the active-low anode and segment lines on the board.
- Latches all four digits once per frame, so a selector switch change never shows a mixed (torn) frame.

---
 rtl/display_7seg_barrido_pkg.sv | 30 +++
 rtl/display_7seg_barrido_decod.sv | 33 +++
 rtl/display_7seg_barrido.sv | 108 ++++++++++
 3 files changed

// File: rtl/display_7seg_barrido_pkg.sv
// Shared constants for the multiplexed 7-segment driver.
// Segment bit order: seg[0]=a, seg[1]=b, ... seg[6]=g; constants are active-low.
package display_7seg_barrido_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF    = 4'b1111;

  // One-hot active-low anode pattern for a digit index.
  function automatic logic [3:0] an_sel(input logic [1:0] idx);
    an_sel = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/display_7seg_barrido_decod.sv
// Hex nibble to 7-segment decoder, purely combinational.
// Output is active-high (1 = segment lit), bit order a..g on [0]..[6].
module decod_hex_7seg
  import display_7seg_barrido_pkg::*;
(
  input  logic [3:0] i_dig,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = '0;
    case (i_dig)
      4'h0: o_seg = ~SEG_0;
      4'h1: o_seg = ~SEG_1;
      4'h2: o_seg = ~SEG_2;
      4'h3: o_seg = ~SEG_3;
      4'h4: o_seg = ~SEG_4;
      4'h5: o_seg = ~SEG_5;
      4'h6: o_seg = ~SEG_6;
      4'h7: o_seg = ~SEG_7;
      4'h8: o_seg = ~SEG_8;
      4'h9: o_seg = ~SEG_9;
      4'hA: o_seg = ~SEG_A;
      4'hB: o_seg = ~SEG_B;
      4'hC: o_seg = ~SEG_C;
      4'hD: o_seg = ~SEG_D;
      4'hE: o_seg = ~SEG_E;
      4'hF: o_seg = ~SEG_F;
      default: o_seg = '0;
    endcase
  end

endmodule

// File: rtl/display_7seg_barrido.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame digit latch and leading-zero blanking.
// Outputs are registered; a slot change is visible one clock after the refresh tick.
module display_7seg_barrido
  import display_7seg_barrido_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] in_0,
  input  logic [3:0] in_1,
  input  logic [3:0] in_2,
  input  logic [3:0] in_3,
  input  logic [3:0] dp_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int             CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0]     r_cnt;
  logic [1:0]        r_idx;
  logic [3:0][3:0]   r_shd;
  logic [3:0]        r_shd_dp;

  logic              w_tick;
  logic              w_wrap;
  logic [1:0]        w_idx_nxt;
  logic [3:0][3:0]   w_shd_nxt;
  logic [3:0]        w_dp_nxt;
  logic [3:0]        w_dig;
  logic [6:0]        w_seg_hi;
  logic [3:0]        w_zero;
  logic [3:0]        w_blank_vec;
  logic              w_blank;
  logic              w_dp_bit;
  logic [3:0]        w_an_nxt;
  logic [6:0]        w_seg_nxt;

  assign w_tick    = enable && (r_cnt == CNT_MAX);
  assign w_wrap    = w_tick && (r_idx == 2'd3);
  assign w_idx_nxt = w_tick ? r_idx + 2'd1 : r_idx;

  // Output regs look at post-edge state so digit 0 of a new frame shows the just-latched inputs.
  assign w_shd_nxt = w_wrap ? {in_3, in_2, in_1, in_0} : r_shd;
  assign w_dp_nxt  = w_wrap ? dp_sel : r_shd_dp;
  assign w_dig     = w_shd_nxt[w_idx_nxt];
  assign w_dp_bit  = w_dp_nxt[w_idx_nxt];

  decod_hex_7seg u_decod (
    .i_dig (w_dig),
    .o_seg (w_seg_hi)
  );

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_zero[k] = (w_shd_nxt[k] == 4'h0);
    end
    w_blank_vec[3] = w_zero[3];
    w_blank_vec[2] = w_zero[3] & w_zero[2];
    w_blank_vec[1] = w_zero[3] & w_zero[2] & w_zero[1];
    w_blank_vec[0] = 1'b0;
    w_blank_vec    = w_blank_vec & {4{BLANK_LZ}};
  end

  assign w_blank = w_blank_vec[w_idx_nxt];

  // A blanked digit keeps its anode only when its decimal point must still be shown.
  assign w_an_nxt  = (!w_blank || w_dp_bit) ? an_sel(w_idx_nxt) : AN_OFF;
  assign w_seg_nxt = w_blank ? SEG_BLANK : ~w_seg_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_idx    <= 2'd0;
      r_shd    <= '0;
      r_shd_dp <= 4'h0;
    end else if (enable) begin
      r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
      r_idx <= w_idx_nxt;
      if (w_wrap) begin
        r_shd    <= w_shd_nxt;
        r_shd_dp <= w_dp_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (enable) begin
      an  <= w_an_nxt;
      seg <= w_seg_nxt;
      dp  <= ~w_dp_bit;
    end else begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end
  end

endmodule
